sequencer_datapath: RTL and testbench
=====================================

Name: sequencer_datapath

Overview:
Registered datapath of the microprogram sequencer. It is the consumer end of the instruction decoder control bus: it takes the decoded strobes (cen, rst, inc, rsel, rce, mux selects, push/pop, stack enables, out_ce, oen) and executes them on the PC, the R register, a LIFO return stack and an output register. It sits directly after the decoder(s), and its outputs feed the microprogram address bus.

Parameters:
WIDTH, 8, data/address width of PC, R, D, Y and stack entries
DEPTH, 4, number of stack entries (>=2)
SPW, $clog2(DEPTH+1), stack pointer width (derived; not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_in  in  WIDTH  external data/branch operand D
rst  in  1  synchronous clear strobe from decoder
cen  in  1  adder enable: Y = A+B when 1, Y = B when 0
inc  in  1  PC update enable
pc_mux_sel  in  1  PC source: 1 = PC+1, 0 = Y
rsel  in  1  R source: 1 = Y, 0 = D
rce  in  1  R load enable
a_mux_sel  in  2  A operand: 00 R, 01 stack top, 10 zero, 11 PC
b_mux_sel  in  2  B operand: 00 PC, 01 stack top, 10 zero, 11 D
push  in  1  stack push request
pop  in  1  stack pop request
stack_we  in  1  stack write enable (qualifies push)
stack_re  in  1  stack read enable (qualifies pop)
src_sel  in  1  push source: 0 = PC, 1 = Y
out_ce  in  1  output register load enable
oen  in  1  output enable
y_out  out  WIDTH  oen ? y_reg : 0
pc_out  out  WIDTH  current PC
r_out  out  WIDTH  current R
stack_top  out  WIDTH  stack[sp-1]; 0 when empty
sp_out  out  SPW  entries held (0..DEPTH)
full  out  1  sp == DEPTH
empty  out  1  sp == 0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset: the interface is already decided. There is one clock, clk. Reset rst_n is asynchronous and active-low. Assertion immediately clears PC, R, y_reg, sp, overflow, underflow and all stack entries to 0. Outputs after reset: y_out=0, pc_out=0, r_out=0, stack_top=0, sp_out=0, full=0, empty=1, overflow=0, underflow=0.
- Y is combinational from the registered state and the current d_in. All arithmetic is modulo 2^WIDTH, with carry discarded.
- Synchronous clear: rst=1 clears PC, R, y_reg, sp and both sticky flags on the next edge. It overrides every other strobe. Stack contents are untouched.
- PC: if inc, PC <= pc_mux_sel ? PC+1 : Y. Otherwise PC holds. PC+1 wraps from all-ones to 0.
- R: if rce, R <= rsel ? Y : d_in.
- Output register: if out_ce, y_reg <= Y. oen gates y_out combinationally only; y_reg is retained while oen=0.
- Stack value source: V = src_sel ? Y : PC, using the pre-edge PC.
- Effective push: eff_push = push & stack_we.
- Effective pop: eff_pop = pop & stack_re.
- Any other combination of push/pop and the enables leaves the stack unchanged.
- eff_push only, not full: stack[sp] <= V, sp <= sp+1.
- eff_push only, full: no change, overflow <= 1.
- eff_pop only, not empty: sp <= sp-1. The entry is not cleared.
- eff_pop only, empty: no change, underflow <= 1.
- eff_push and eff_pop, not empty: replace top, stack[sp-1] <= V, sp unchanged.
- eff_push and eff_pop, empty: behaves as a push.
- Operand ordering: all register updates in one cycle use pre-edge values. For example, a_mux_sel=01 with a pop reads the old top.
- Latency: every strobe takes effect on the next rising edge. stack_top, full and empty reflect the new sp in the following cycle.
- Sticky flags clear only on rst_n or rst.

Decomposition:
- Package seq_pkg holds the A/B mux encodings (A_R, A_STK, A_ZERO, A_PC; B_PC, B_STK, B_ZERO, B_D) and the src_sel/pc_mux_sel/rsel localparams. The decoder shares these.
- One sub-module, seq_stack, owns the LIFO storage, sp, full/empty and overflow/underflow. It has ports clk, rst_n, clr, eff_push, eff_pop, din, top, sp, full, empty, ovf, unf.
- The parent holds PC, R, y_reg and the operand muxes.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with PC=0x12 -> all outputs at reset values immediately, empty=1.
- PC to R with PC=0x05: apply a=10, b=00, cen=0, rsel=1, rce=1, inc=1, pc_mux_sel=1, out_ce=1, oen=1 -> next cycle R=0x05, y_out=0x05, PC=0x06. Set oen=0 -> y_out=0x00 with y_reg kept.
- R plus D with wrap: R=0x05, d_in=0xFB, a=00, b=11, cen=1, rsel=1, rce=1 -> R=0x00, PC=0x07 when inc=1.
- Push overflow: with PC at 0x10, 5 cycles of push=stack_we=1, src_sel=0, inc=1 -> entries 0x10..0x13, full=1 after the 4th, 5th ignored, overflow=1, sp_out=4.
- Stack edges: pop with stack_re=1 on empty -> underflow=1, sp_out=0. At sp=2, push+pop with src_sel=1 and Y=0xAA -> stack_top=0xAA, sp_out=2. Then pop with stack_re=0 -> no change.
- Synchronous clear: rst=1 together with push, inc and rce -> PC=0, R=0, sp=0, flags=0, and no push occurs.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the sequencer datapath and its instruction decoder.
package seq_pkg;

   localparam logic [1:0] A_R    = 2'b00;
   localparam logic [1:0] A_STK  = 2'b01;
   localparam logic [1:0] A_ZERO = 2'b10;
   localparam logic [1:0] A_PC   = 2'b11;

   localparam logic [1:0] B_PC   = 2'b00;
   localparam logic [1:0] B_STK  = 2'b01;
   localparam logic [1:0] B_ZERO = 2'b10;
   localparam logic [1:0] B_D    = 2'b11;

   localparam logic SRC_PC     = 1'b0;
   localparam logic SRC_Y      = 1'b1;

   localparam logic PC_SEL_Y   = 1'b0;
   localparam logic PC_SEL_INC = 1'b1;

   localparam logic RSEL_D     = 1'b0;
   localparam logic RSEL_Y     = 1'b1;

endpackage

// File: rtl/seq_stack.sv
// LIFO return stack: storage, pointer, full/empty and sticky over/underflow.
module seq_stack #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int SPW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             eff_push,
   input  logic             eff_pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [SPW-1:0]   sp,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    top_idx;

   // sp is never used as an index when full, and sp-1 never when empty
   assign wr_idx  = IW'(sp);
   assign top_idx = IW'(sp - SPW'(1));
   assign full    = (sp == SPW'(DEPTH));
   assign empty   = (sp == '0);
   assign top     = empty ? '0 : mem[top_idx];

   // Push/pop/replace-top; push+pop on an empty stack degrades to a push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (eff_push && eff_pop && !empty) begin
         mem[top_idx] <= din;
      end else if (eff_push) begin
         if (full) begin
            ovf <= 1'b1;
         end else begin
            mem[wr_idx] <= din;
            sp          <= sp + SPW'(1);
         end
      end else if (eff_pop) begin
         if (empty) unf <= 1'b1;
         else       sp  <= sp - SPW'(1);
      end
   end

endmodule

// File: rtl/sequencer_datapath.sv
// Sequencer datapath: PC, R, output register and operand muxes around the return stack.
module sequencer_datapath #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int SPW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_in,
   input  logic             rst,
   input  logic             cen,
   input  logic             inc,
   input  logic             pc_mux_sel,
   input  logic             rsel,
   input  logic             rce,
   input  logic [1:0]       a_mux_sel,
   input  logic [1:0]       b_mux_sel,
   input  logic             push,
   input  logic             pop,
   input  logic             stack_we,
   input  logic             stack_re,
   input  logic             src_sel,
   input  logic             out_ce,
   input  logic             oen,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] stack_top,
   output logic [SPW-1:0]   sp_out,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   import seq_pkg::*;

   logic [WIDTH-1:0] pc, r, y_reg;
   logic [WIDTH-1:0] a_op, b_op, y;
   logic [WIDTH-1:0] pc_nxt, r_nxt, push_val;
   logic             eff_push, eff_pop;

   // Operand selection and the adder; carry out is dropped
   always_comb begin
      a_op     = '0;
      b_op     = '0;
      pc_nxt   = pc;
      r_nxt    = r;
      push_val = pc;
      case (a_mux_sel)
         A_R:    a_op = r;
         A_STK:  a_op = stack_top;
         A_ZERO: a_op = '0;
         A_PC:   a_op = pc;
      endcase
      case (b_mux_sel)
         B_PC:   b_op = pc;
         B_STK:  b_op = stack_top;
         B_ZERO: b_op = '0;
         B_D:    b_op = d_in;
      endcase
      y = cen ? (a_op + b_op) : b_op;
      case (pc_mux_sel)
         PC_SEL_INC: pc_nxt = pc + WIDTH'(1);
         PC_SEL_Y:   pc_nxt = y;
      endcase
      case (rsel)
         RSEL_Y: r_nxt = y;
         RSEL_D: r_nxt = d_in;
      endcase
      case (src_sel)
         SRC_Y:  push_val = y;
         SRC_PC: push_val = pc;
      endcase
   end

   // PC, R and output register; rst overrides every other strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= '0;
         r     <= '0;
         y_reg <= '0;
      end else if (rst) begin
         pc    <= '0;
         r     <= '0;
         y_reg <= '0;
      end else begin
         if (inc)    pc    <= pc_nxt;
         if (rce)    r     <= r_nxt;
         if (out_ce) y_reg <= y;
      end
   end

   assign eff_push = push & stack_we;
   assign eff_pop  = pop & stack_re;

   seq_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (rst),
      .eff_push (eff_push),
      .eff_pop  (eff_pop),
      .din      (push_val),
      .top      (stack_top),
      .sp       (sp_out),
      .full     (full),
      .empty    (empty),
      .ovf      (overflow),
      .unf      (underflow)
   );

   assign y_out  = oen ? y_reg : '0;
   assign pc_out = pc;
   assign r_out  = r;

endmodule

// File: tb/tb_sequencer_datapath.sv
// Bench for sequencer_datapath: directed scenarios plus random strobes against a queue-based model.
module tb_sequencer_datapath;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SPW   = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] d_in;
   logic             rst, cen, inc, pc_mux_sel, rsel, rce;
   logic [1:0]       a_mux_sel, b_mux_sel;
   logic             push, pop, stack_we, stack_re, src_sel, out_ce, oen;
   logic [WIDTH-1:0] y_out, pc_out, r_out, stack_top;
   logic [SPW-1:0]   sp_out;
   logic             full, empty, overflow, underflow;

   int total = 0;
   int bad   = 0;

   sequencer_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .rst(rst), .cen(cen), .inc(inc),
      .pc_mux_sel(pc_mux_sel), .rsel(rsel), .rce(rce), .a_mux_sel(a_mux_sel),
      .b_mux_sel(b_mux_sel), .push(push), .pop(pop), .stack_we(stack_we),
      .stack_re(stack_re), .src_sel(src_sel), .out_ce(out_ce), .oen(oen),
      .y_out(y_out), .pc_out(pc_out), .r_out(r_out), .stack_top(stack_top),
      .sp_out(sp_out), .full(full), .empty(empty), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Reference model: architectural registers and a queue as the stack
   logic [7:0] m_pc, m_r, m_yreg;
   logic [7:0] m_stk[$];
   bit         m_ovf, m_unf;

   function automatic logic [7:0] m_top();
      return (m_stk.size() == 0) ? 8'h00 : m_stk[m_stk.size() - 1];
   endfunction

   function automatic logic [7:0] m_y();
      int a, b;
      case (a_mux_sel)
         2'd0: a = m_r;
         2'd1: a = m_top();
         2'd2: a = 0;
         default: a = m_pc;
      endcase
      case (b_mux_sel)
         2'd0: b = m_pc;
         2'd1: b = m_top();
         2'd2: b = 0;
         default: b = d_in;
      endcase
      return cen ? 8'((a + b) % 256) : 8'(b);
   endfunction

   task automatic model_reset();
      m_pc = 0; m_r = 0; m_yreg = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
   endtask

   task automatic model_step();
      logic [7:0] y, v;
      bit ep, epp;
      y   = m_y();
      v   = src_sel ? y : m_pc;
      ep  = push && stack_we;
      epp = pop && stack_re;
      if (rst) begin
         m_pc = 0; m_r = 0; m_yreg = 0; m_ovf = 0; m_unf = 0;
         m_stk.delete();
      end else begin
         if (ep && epp) begin
            if (m_stk.size() == 0) m_stk.push_back(v);
            else m_stk[m_stk.size() - 1] = v;
         end else if (ep) begin
            if (m_stk.size() == DEPTH) m_ovf = 1;
            else m_stk.push_back(v);
         end else if (epp) begin
            if (m_stk.size() == 0) m_unf = 1;
            else void'(m_stk.pop_back());
         end
         if (inc) m_pc = pc_mux_sel ? m_pc + 8'd1 : y;
         if (rce) m_r = rsel ? y : d_in;
         if (out_ce) m_yreg = y;
      end
   endtask

   task automatic idle();
      d_in = 0; rst = 0; cen = 0; inc = 0; pc_mux_sel = 0; rsel = 0; rce = 0;
      a_mux_sel = 2'd2; b_mux_sel = 2'd2; push = 0; pop = 0; stack_we = 0;
      stack_re = 0; src_sel = 0; out_ce = 0; oen = 1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pc(input logic [7:0] val);
      idle();
      d_in = val; a_mux_sel = 2'd2; b_mux_sel = 2'd3; inc = 1; pc_mux_sel = 0;
      tick();
      idle();
   endtask

   task automatic test_reset();
      load_pc(8'h12);
      total++;
      if (pc_out !== 8'h12) begin
         bad++; $display("FAIL reset_preload: pc got %h want 12", pc_out);
      end
      @(negedge clk);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      total++;
      if ({y_out, pc_out, r_out, stack_top, sp_out, full, overflow, underflow} !== 38'h0) begin
         bad++;
         $display("FAIL reset_outputs: y=%h pc=%h r=%h top=%h sp=%0d full=%b ovf=%b unf=%b want all 0",
                  y_out, pc_out, r_out, stack_top, sp_out, full, overflow, underflow);
      end
      total++;
      if (empty !== 1'b1) begin
         bad++; $display("FAIL reset_empty: got %b want 1", empty);
      end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_pc_to_r();
      load_pc(8'h05);
      a_mux_sel = 2'd2; b_mux_sel = 2'd0; cen = 0; rsel = 1; rce = 1;
      inc = 1; pc_mux_sel = 1; out_ce = 1; oen = 1;
      tick();
      idle();
      total++;
      if (r_out !== 8'h05) begin bad++; $display("FAIL pc_to_r_r: got %h want 05", r_out); end
      total++;
      if (y_out !== 8'h05) begin bad++; $display("FAIL pc_to_r_y: got %h want 05", y_out); end
      total++;
      if (pc_out !== 8'h06) begin bad++; $display("FAIL pc_to_r_pc: got %h want 06", pc_out); end
      oen = 0;
      #1;
      total++;
      if (y_out !== 8'h00) begin bad++; $display("FAIL oen_gate: got %h want 00", y_out); end
      oen = 1;
      #1;
      total++;
      if (y_out !== 8'h05) begin bad++; $display("FAIL yreg_kept: got %h want 05", y_out); end
   endtask

   task automatic test_wrap();
      idle();
      d_in = 8'hFB; a_mux_sel = 2'd0; b_mux_sel = 2'd3; cen = 1; rsel = 1; rce = 1;
      inc = 1; pc_mux_sel = 1;
      tick();
      idle();
      total++;
      if (r_out !== 8'h00) begin bad++; $display("FAIL wrap_r: got %h want 00", r_out); end
      total++;
      if (pc_out !== 8'h07) begin bad++; $display("FAIL wrap_pc: got %h want 07", pc_out); end
   endtask

   task automatic test_push_overflow();
      idle(); rst = 1; tick();
      load_pc(8'h10);
      for (int i = 0; i < 5; i++) begin
         idle();
         push = 1; stack_we = 1; src_sel = 0; inc = 1; pc_mux_sel = 1;
         tick();
         idle();
         if (i == 3) begin
            total++;
            if (full !== 1'b1) begin bad++; $display("FAIL push_full: got %b want 1", full); end
            total++;
            if (overflow !== 1'b0) begin bad++; $display("FAIL push_no_ovf_yet: got %b want 0", overflow); end
         end
      end
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL push_ovf: got %b want 1", overflow); end
      total++;
      if (sp_out !== 3'd4) begin bad++; $display("FAIL push_sp: got %0d want 4", sp_out); end
      total++;
      if (stack_top !== 8'h13) begin bad++; $display("FAIL push_top: got %h want 13", stack_top); end
   endtask

   task automatic test_stack_edges();
      idle(); rst = 1; tick();
      idle(); pop = 1; stack_re = 1; tick(); idle();
      total++;
      if (underflow !== 1'b1) begin bad++; $display("FAIL pop_unf: got %b want 1", underflow); end
      total++;
      if (sp_out !== 3'd0) begin bad++; $display("FAIL pop_sp: got %0d want 0", sp_out); end
      for (int i = 0; i < 2; i++) begin
         idle(); push = 1; stack_we = 1; tick();
      end
      idle();
      push = 1; pop = 1; stack_we = 1; stack_re = 1; src_sel = 1;
      a_mux_sel = 2'd2; b_mux_sel = 2'd3; cen = 0; d_in = 8'hAA;
      tick();
      idle();
      total++;
      if (stack_top !== 8'hAA) begin bad++; $display("FAIL replace_top: got %h want aa", stack_top); end
      total++;
      if (sp_out !== 3'd2) begin bad++; $display("FAIL replace_sp: got %0d want 2", sp_out); end
      pop = 1; stack_re = 0;
      tick();
      idle();
      total++;
      if (sp_out !== 3'd2) begin bad++; $display("FAIL pop_gated_sp: got %0d want 2", sp_out); end
      total++;
      if (stack_top !== 8'hAA) begin bad++; $display("FAIL pop_gated_top: got %h want aa", stack_top); end
   endtask

   task automatic test_sync_clear();
      idle(); d_in = 8'h33; rce = 1; rsel = 0; inc = 1; pc_mux_sel = 1; tick();
      idle();
      rst = 1; push = 1; stack_we = 1; inc = 1; pc_mux_sel = 1; rce = 1; rsel = 0;
      out_ce = 1; d_in = 8'h77; b_mux_sel = 2'd3;
      tick();
      idle();
      total++;
      if (pc_out !== 8'h00) begin bad++; $display("FAIL clr_pc: got %h want 00", pc_out); end
      total++;
      if (r_out !== 8'h00) begin bad++; $display("FAIL clr_r: got %h want 00", r_out); end
      total++;
      if (sp_out !== 3'd0 || empty !== 1'b1) begin
         bad++; $display("FAIL clr_sp: sp %0d empty %b want 0 1", sp_out, empty);
      end
      total++;
      if ({overflow, underflow} !== 2'b00) begin
         bad++; $display("FAIL clr_flags: got %b%b want 00", overflow, underflow);
      end
      total++;
      if (y_out !== 8'h00) begin bad++; $display("FAIL clr_y: got %h want 00", y_out); end
   endtask

   task automatic test_random();
      logic [38:0] act, exp;
      logic [7:0]  ey;
      for (int n = 0; n < 400; n++) begin
         d_in       = 8'($urandom);
         rst        = ($urandom_range(0, 40) == 0);
         cen        = 1'($urandom);
         inc        = 1'($urandom);
         pc_mux_sel = 1'($urandom);
         rsel       = 1'($urandom);
         rce        = 1'($urandom);
         a_mux_sel  = 2'($urandom);
         b_mux_sel  = 2'($urandom);
         push       = 1'($urandom);
         pop        = 1'($urandom);
         stack_we   = ($urandom_range(0, 3) != 0);
         stack_re   = ($urandom_range(0, 3) != 0);
         src_sel    = 1'($urandom);
         out_ce     = 1'($urandom);
         oen        = ($urandom_range(0, 3) != 0);
         tick();
         ey  = oen ? m_yreg : 8'h00;
         exp = {ey, m_pc, m_r, m_top(), 3'(m_stk.size()), (m_stk.size() == DEPTH),
                (m_stk.size() == 0), m_ovf, m_unf};
         act = {y_out, pc_out, r_out, stack_top, sp_out, full, empty, overflow, underflow};
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL random_%0d: got y/pc/r/top/sp/fl %h want %h", n, act, exp);
         end
      end
   endtask

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      test_reset();
      test_pc_to_r();
      test_wrap();
      test_push_overflow();
      test_stack_edges();
      test_sync_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
